tp_mux: RTL and testbench
=========================

TP_MUX -- requirements
Module: tp_mux

Interface
REQ-001 Parameter NCH, default 16, number of test-point channels (2..32).
REQ-002 Parameter NSRC, default 4, number of selectable source groups (1..8), each NCH bits wide.
REQ-003 Parameter STRETCH, default 8, pulse-stretch length in CLK cycles (1..255).
REQ-004 CLK  in  1  fabric clock; all logic is in this domain.
REQ-005 RST  in  1  synchronous, active-high reset, sampled on the rising edge of CLK.
REQ-006 SRC  in  NSRC*NCH  source groups; group g occupies bits [g*NCH +: NCH].
REQ-007 CFG_WE  in  1  configuration write strobe, one cycle per write.
REQ-008 CFG_ADDR  in  2  register address: 0 group select, 1 mode, 2 direction mask, 3 freeze.
REQ-009 CFG_DATA  in  NCH  configuration write data.
REQ-010 TP_IN  in  NCH  pad input values, asynchronous to CLK.
REQ-011 TP_OUT  out  NCH  registered drive value to pad buffers.
REQ-012 TP_DIR  out  NCH  per-channel direction: 1 tri-state (input), 0 drive.
REQ-013 TP_IN_SYNC  out  NCH  TP_IN after a two-flop synchronizer.
REQ-014 CFG_GRP  out  3  current group select, for readback.

Function
REQ-015 Registers: GRP <= CFG_DATA[2:0] (addr 0); MODE <= CFG_DATA[1:0] (addr 1); DIR <= CFG_DATA (addr 2); FRZ <= CFG_DATA[0] (addr 3).
REQ-016 The selected vector cur = SRC group GRP when GRP < NSRC; otherwise all zeros.
REQ-017 A per-channel prev register holds cur from the previous cycle; rise = cur & ~prev.
REQ-018 MODE 0 (direct): TP_OUT <= cur, giving 1-cycle latency from SRC to TP_OUT.
REQ-019 MODE 1 (stretch), per channel:
- on rise: cnt <= STRETCH-1, out <= 1;
- else if cnt != 0: cnt <= cnt-1, out <= 1;
- else out <= cur.
- A rise during an active count reloads cnt to STRETCH-1.
REQ-020 MODE 2 (toggle): the per-channel toggle bit inverts on each rise, and TP_OUT <= toggle bit.
REQ-021 MODE 3: TP_OUT <= 0.
REQ-022 A write to addr 0 or 1 clears all cnt and toggle bits and loads prev <= new cur, so no rise is detected in the following cycle. This write takes precedence over any simultaneous rise.
REQ-023 While FRZ = 1, TP_OUT holds its value, and cnt, toggle and prev continue to update. On the first cycle after FRZ clears, TP_OUT reflects the current internal state.
REQ-024 TP_DIR = DIR, registered, and changes 1 cycle after the write.
REQ-025 TP_IN_SYNC has exactly 2 cycles of latency from TP_IN.
REQ-026 The cnt width is the minimum needed to hold STRETCH-1, and cnt never wraps below 0.

Reset
REQ-027 Reset values: GRP = 0, MODE = 0, DIR = all ones (safe, all tri-state), FRZ = 0.
REQ-028 TP_OUT, cnt, toggle, prev and both synchronizer stages all reset to 0.
REQ-029 RST overrides a simultaneous CFG_WE.
REQ-030 Reset asserted mid-stretch or mid-toggle ends the activity, and TP_OUT = 0 on the cycle after RST is sampled.

Configuration
REQ-031 Macro TP_MUX_STRETCH_EN compiles in the stretch counters and MODE 1 logic.
REQ-032 Without TP_MUX_STRETCH_EN, no counters are instantiated and MODE 1 behaves exactly as MODE 0.

Verification
REQ-033 Write addr 0 = 2, drive group-2 bit 5 high for 1 cycle -> TP_OUT[5] high for exactly 1 cycle, 1 cycle after SRC.
REQ-034 MODE 1, single-cycle pulse on channel 0 -> TP_OUT[0] high for 8 cycles. A second pulse 5 cycles after the first -> high for 13 cycles total.
REQ-035 MODE 2, 4 single-cycle pulses on channel 3 -> TP_OUT[3] sequence 1,0,1,0, with no change between pulses.
REQ-036 Write addr 0 = 5 (>= NSRC) -> TP_OUT = 0x0000. Group write coincident with a rise -> no stretch or toggle is started.
REQ-037 FRZ = 1 with TP_OUT = 0x00FF, then SRC changes -> TP_OUT stays 0x00FF. On FRZ = 0, TP_OUT follows SRC on the next cycle.
REQ-038 RST during a stretch -> TP_OUT = 0, TP_DIR = 0xFFFF, CFG_GRP = 0. TP_IN step -> TP_IN_SYNC follows after 2 cycles.

Source files
------------

// File: rtl/tp_mux.sv
// ---------------------------------------------------------------------------
// tp_mux -- test-point multiplexer for bring-up and debug.
//
// Selects one of NSRC source groups and drives it onto NCH test-point pads.
// Three drive modes are available: direct, pulse-stretch and toggle-on-rise.
// A freeze bit holds the pad value while the internal state keeps running.
// Pad inputs are brought into the clk domain through a two-flop synchronizer.
//
// Optional build macro:
//   TP_MUX_STRETCH_EN  compiles in the per-channel stretch counters used by
//                      mode 1; without it mode 1 is identical to mode 0.
//
// Ports:
//   clk         fabric clock, all logic is in this domain
//   rst         synchronous active-high reset
//   src         NSRC source groups, group g at [g*NCH +: NCH]
//   cfg_we      configuration write strobe (one cycle per write)
//   cfg_addr    0 group select, 1 mode, 2 direction mask, 3 freeze
//   cfg_data    configuration write data
//   tp_in       pad input values (asynchronous)
//   tp_out      registered pad drive value
//   tp_dir      per-channel direction, 1 = tri-state, 0 = drive
//   tp_in_sync  tp_in after the two-flop synchronizer
//   cfg_grp     current group select, for readback
// ---------------------------------------------------------------------------
module tp_mux #(
    parameter int NCH     = 16,
    parameter int NSRC    = 4,
    parameter int STRETCH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NSRC*NCH-1:0] src,
    input  logic                cfg_we,
    input  logic [1:0]          cfg_addr,
    input  logic [NCH-1:0]      cfg_data,
    input  logic [NCH-1:0]      tp_in,
    output logic [NCH-1:0]      tp_out,
    output logic [NCH-1:0]      tp_dir,
    output logic [NCH-1:0]      tp_in_sync,
    output logic [2:0]          cfg_grp
);

    localparam logic [1:0] ADDR_GRP  = 2'd0;
    localparam logic [1:0] ADDR_MODE = 2'd1;
    localparam logic [1:0] ADDR_DIR  = 2'd2;
    localparam logic [1:0] ADDR_FRZ  = 2'd3;

    localparam logic [1:0] MODE_DIRECT  = 2'd0;
    localparam logic [1:0] MODE_STRETCH = 2'd1;
    localparam logic [1:0] MODE_TOGGLE  = 2'd2;

    logic [2:0]     grp;
    logic [1:0]     mode;
    logic           frz;
    logic [NCH-1:0] dir;
    logic [NCH-1:0] prev;
    logic [NCH-1:0] tog;
    logic [NCH-1:0] sync1;

    logic           wr_grp;
    logic           wr_gm;
    logic [NCH-1:0] cur;
    logic [NCH-1:0] cur_new;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] tog_nxt;
    logic [NCH-1:0] str_out;
    logic [NCH-1:0] out_nxt;

    function automatic logic [NCH-1:0] pick(input logic [2:0]          g,
                                            input logic [NSRC*NCH-1:0] s);
        logic [NCH-1:0] v;
        v = '0;
        for (int i = 0; i < NSRC; i++)
            if (g == 3'(i)) v = s[i*NCH +: NCH];
        return v;
    endfunction

    // A group or mode write restarts edge detection: prev is loaded with the
    // vector that will be selected next cycle, and rise is masked so that no
    // stretch or toggle can start on the write cycle itself.
    always_comb begin
        wr_grp  = cfg_we && (cfg_addr == ADDR_GRP);
        wr_gm   = wr_grp || (cfg_we && (cfg_addr == ADDR_MODE));
        cur     = pick(grp, src);
        cur_new = wr_grp ? pick(3'(cfg_data), src) : cur;
        rise    = wr_gm ? '0 : (cur & ~prev);
        tog_nxt = wr_gm ? '0 : (tog ^ rise);
    end

`ifdef TP_MUX_STRETCH_EN
    localparam int CW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(STRETCH - 1);

    logic [NCH-1:0][CW-1:0] cnt;
    logic [NCH-1:0][CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = '0;
        str_out = cur;
        for (int c = 0; c < NCH; c++) begin
            if (wr_gm) begin
                cnt_nxt[c] = '0;
            end else if (rise[c]) begin
                cnt_nxt[c] = CNT_LOAD;
                str_out[c] = 1'b1;
            end else if (cnt[c] != '0) begin
                cnt_nxt[c] = cnt[c] - CW'(1);
                str_out[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end
`else
    // No counters: stretch degenerates to the direct path. An out-of-range
    // STRETCH below 1 parks the path low instead.
    assign str_out = (STRETCH >= 1) ? cur : '0;
`endif

    always_comb begin
        case (mode)
            MODE_DIRECT:  out_nxt = cur;
            MODE_STRETCH: out_nxt = str_out;
            MODE_TOGGLE:  out_nxt = tog_nxt;
            default:      out_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grp        <= '0;
            mode       <= MODE_DIRECT;
            dir        <= '1;
            frz        <= 1'b0;
            prev       <= '0;
            tog        <= '0;
            tp_out     <= '0;
            sync1      <= '0;
            tp_in_sync <= '0;
        end else begin
            prev       <= cur_new;
            tog        <= tog_nxt;
            // Freeze only holds the pad value; edge state keeps tracking.
            if (!frz) tp_out <= out_nxt;
            sync1      <= tp_in;
            tp_in_sync <= sync1;
            if (cfg_we) begin
                case (cfg_addr)
                    ADDR_GRP:  grp  <= 3'(cfg_data);
                    ADDR_MODE: mode <= 2'(cfg_data);
                    ADDR_DIR:  dir  <= cfg_data;
                    ADDR_FRZ:  frz  <= cfg_data[0];
                endcase
            end
        end
    end

    assign tp_dir  = dir;
    assign cfg_grp = grp;

endmodule

// File: tb/tb_tp_mux.sv
// Self-checking bench for tp_mux: behavioural model compared every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_tp_mux;
    localparam int NCH     = 16;
    localparam int NSRC    = 4;
    localparam int STRETCH = 8;
    localparam int NEVER   = -1000000;
`ifdef TP_MUX_STRETCH_EN
    localparam bit STR_EN = 1'b1;
`else
    localparam bit STR_EN = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NSRC*NCH-1:0] src;
    logic                cfg_we;
    logic [1:0]          cfg_addr;
    logic [NCH-1:0]      cfg_data;
    logic [NCH-1:0]      tp_in;
    logic [NCH-1:0]      tp_out;
    logic [NCH-1:0]      tp_dir;
    logic [NCH-1:0]      tp_in_sync;
    logic [2:0]          cfg_grp;

    tp_mux #(.NCH(NCH), .NSRC(NSRC), .STRETCH(STRETCH)) dut (
        .clk        (clk),
        .rst        (rst),
        .src        (src),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .tp_in      (tp_in),
        .tp_out     (tp_out),
        .tp_dir     (tp_dir),
        .tp_in_sync (tp_in_sync),
        .cfg_grp    (cfg_grp)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH-1:0] grp_of(input logic [2:0] g, input logic [NSRC*NCH-1:0] s);
        if (int'(g) < NSRC) return s[int'(g)*NCH +: NCH];
        return '0;
    endfunction

    // ---------------- behavioural model ----------------
    // Stretch: a channel is high while fewer than STRETCH cycles have passed
    // since its last rise. Toggle: parity of the number of rises seen.
    logic [NCH-1:0] m_prev, m_dir, e_out, e_sync, m_h;
    logic [2:0]     m_grp;
    logic [1:0]     m_mode;
    logic           m_frz;
    int             m_last [NCH];
    int             m_tog  [NCH];
    int             cyc     = 0;
    bit             m_valid = 1'b0;

    initial begin
        logic [NCH-1:0] cur, nxt, o_str, o_tog;
        bit gm;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_grp = '0; m_mode = '0; m_dir = '1; m_frz = 1'b0;
                m_prev = '0; e_out = '0; e_sync = '0; m_h = '0;
                for (int c = 0; c < NCH; c++) begin
                    m_last[c] = NEVER;
                    m_tog[c]  = 0;
                end
                m_valid = 1'b1;
            end else begin
                cur = grp_of(m_grp, src);
                gm  = cfg_we && (cfg_addr <= 2'd1);
                for (int c = 0; c < NCH; c++) begin
                    if (gm) begin
                        m_last[c] = NEVER;
                        m_tog[c]  = 0;
                    end else if (cur[c] && !m_prev[c]) begin
                        m_last[c] = cyc;
                        m_tog[c]  = m_tog[c] + 1;
                    end
                    o_str[c] = ((cyc - m_last[c]) < STRETCH) ? 1'b1 : cur[c];
                    o_tog[c] = (m_tog[c] % 2) == 1;
                end
                case (m_mode)
                    2'd0:    nxt = cur;
                    2'd1:    nxt = STR_EN ? o_str : cur;
                    2'd2:    nxt = o_tog;
                    default: nxt = '0;
                endcase
                if (!m_frz) e_out = nxt;
                e_sync = m_h;
                m_h    = tp_in;
                m_prev = (cfg_we && cfg_addr == 2'd0) ? grp_of(cfg_data[2:0], src) : cur;
                if (cfg_we) begin
                    case (cfg_addr)
                        2'd0: m_grp  = cfg_data[2:0];
                        2'd1: m_mode = cfg_data[1:0];
                        2'd2: m_dir  = cfg_data;
                        default: m_frz = cfg_data[0];
                    endcase
                end
                cyc++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("model_tp_out", tp_out, e_out);
            chk("model_tp_dir", tp_dir, m_dir);
            chk("model_tp_in_sync", tp_in_sync, e_sync);
            chk("model_cfg_grp", cfg_grp, m_grp);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg(input logic [1:0] a, input logic [NCH-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        int hi;
        int exp_cnt;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; src = '0; tp_in = '0;
        tick(); tick();
        chk("rst_tp_out", tp_out, 0);
        chk("rst_tp_dir", tp_dir, 16'hFFFF);
        chk("rst_cfg_grp", cfg_grp, 0);
        chk("rst_sync", tp_in_sync, 0);
        rst = 1'b0;

        // direct mode, group 2 bit 5 one-cycle pulse
        cfg(2'd0, 16'd2);
        chk("grp_readback", cfg_grp, 3'd2);
        chk("direct_idle", tp_out, 0);
        src[2*NCH+5] = 1'b1; tick();
        chk("direct_hi", tp_out, 16'h0020);
        src = '0; tick();
        chk("direct_lo", tp_out, 0);

        // stretch mode: single pulse, then two pulses five cycles apart
        cfg(2'd1, 16'd1); tick();
        hi = 0;
        src[2*NCH] = 1'b1; tick(); hi += int'(tp_out[0]);
        src = '0;
        repeat (19) begin tick(); hi += int'(tp_out[0]); end
        exp_cnt = STR_EN ? 8 : 1;
        chk("stretch_single_len", 32'(hi), 32'(exp_cnt));
        hi = 0;
        src[2*NCH] = 1'b1; tick(); hi += int'(tp_out[0]);
        src = '0;
        repeat (4) begin tick(); hi += int'(tp_out[0]); end
        src[2*NCH] = 1'b1; tick(); hi += int'(tp_out[0]);
        src = '0;
        repeat (20) begin tick(); hi += int'(tp_out[0]); end
        exp_cnt = STR_EN ? 13 : 2;
        chk("stretch_retrig_len", 32'(hi), 32'(exp_cnt));

        // toggle mode: four pulses on channel 3
        cfg(2'd1, 16'd2); tick();
        for (int k = 0; k < 4; k++) begin
            src[2*NCH+3] = 1'b1; tick();
            chk("toggle_pulse", 32'(tp_out[3]), 32'((k % 2) == 0));
            src = '0;
            repeat (3) tick();
            chk("toggle_hold", 32'(tp_out[3]), 32'((k % 2) == 0));
        end

        // out-of-range group
        cfg(2'd1, 16'd0);
        src = '1; tick();
        cfg(2'd0, 16'd5); tick();
        chk("grp_oob_out", tp_out, 0);
        chk("grp_oob_rb", cfg_grp, 3'd5);

        // group write coincident with a rise starts nothing
        src = '0; cfg(2'd0, 16'd2); cfg(2'd1, 16'd1); tick();
        src[2*NCH+4] = 1'b1; cfg(2'd0, 16'd2);
        src = '0; tick();
        chk("coinc_stretch", tp_out, 0);
        cfg(2'd1, 16'd2); tick();
        src[2*NCH+4] = 1'b1; cfg(2'd0, 16'd2); tick();
        chk("coinc_toggle", tp_out, 0);
        src = '0; tick();

        // freeze
        cfg(2'd1, 16'd0);
        src[2*NCH +: NCH] = 16'h00FF; tick();
        chk("frz_pre", tp_out, 16'h00FF);
        cfg(2'd3, 16'd1);
        src[2*NCH +: NCH] = 16'hAB00;
        repeat (3) tick();
        chk("frz_hold", tp_out, 16'h00FF);
        cfg(2'd3, 16'd0);
        chk("frz_last_hold", tp_out, 16'h00FF);
        tick();
        chk("frz_release", tp_out, 16'hAB00);

        // direction, reset mid-stretch with a coincident write, synchronizer
        cfg(2'd2, 16'h1234);
        chk("dir_write", tp_dir, 16'h1234);
        src = '0; cfg(2'd1, 16'd1); tick();
        src[2*NCH] = 1'b1; tick();
        src = '0; tick(); tick();
        rst = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 16'h0000;
        tick();
        rst = 1'b0; cfg_we = 1'b0;
        chk("rst_mid_out", tp_out, 0);
        chk("rst_mid_dir", tp_dir, 16'hFFFF);
        chk("rst_mid_grp", cfg_grp, 0);
        tick();
        chk("rst_after_out", tp_out, 0);
        tp_in = 16'hA5A5; tick();
        chk("sync_stage1", tp_in_sync, 0);
        tick();
        chk("sync_stage2", tp_in_sync, 16'hA5A5);

        // randomized phase
        repeat (4000) begin
            if ($urandom_range(0, 2) == 0)
                src = {32'($urandom) & 32'($urandom), 32'($urandom) & 32'($urandom)};
            tp_in    = 16'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
            cfg_we   = ($urandom_range(0, 9) == 0);
            cfg_addr = 2'($urandom);
            cfg_data = 16'($urandom);
            if (cfg_addr == 2'd3) cfg_data[0] = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 1'b0; cfg_we = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
